// File: rtl/binary_demux_3_stream.sv
// Registered 1-to-3 stream demultiplexer with a one-word holding register per channel.
// Words selecting channel 3 are dropped and counted; err stays set until reset.
module binary_demux_3_stream #(
    parameter int k     = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [k-1:0]     a,
    input  logic [1:0]       sb,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [k-1:0]     b0,
    output logic [k-1:0]     b1,
    output logic [k-1:0]     b2,
    output logic [2:0]       b_valid,
    input  logic [2:0]       b_ready,
    output logic             err,
    output logic [CNT_W-1:0] drop_cnt
);

    logic         in_xfer;
    logic [2:0]   load;
    logic         drop;
    logic [k-1:0] data_q [3];

    // A channel can accept when it is empty or is being drained in the same cycle.
    always_comb begin
        case (sb)
            2'd0:    a_ready = ~b_valid[0] | b_ready[0];
            2'd1:    a_ready = ~b_valid[1] | b_ready[1];
            2'd2:    a_ready = ~b_valid[2] | b_ready[2];
            default: a_ready = 1'b1;
        endcase
    end

    assign in_xfer = a_valid & a_ready;

    always_comb begin
        load = 3'b000;
        drop = 1'b0;
        if (in_xfer) begin
            case (sb)
                2'd0:    load = 3'b001;
                2'd1:    load = 3'b010;
                2'd2:    load = 3'b100;
                default: drop = 1'b1;
            endcase
        end
    end

    // A new word wins over a drain, so valid stays high on simultaneous in/out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load[i]) begin
                    b_valid[i] <= 1'b1;
                    data_q[i]  <= a;
                end else if (b_ready[i]) begin
                    b_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            err <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign b0 = data_q[0];
    assign b1 = data_q[1];
    assign b2 = data_q[2];

endmodule

// File: tb/tb_binary_demux_3_stream.sv
// Self-checking bench for binary_demux_3_stream: directed routing, back-pressure,
// throughput, drop/saturation and async reset cases, then a long random run against a scoreboard.
module tb_binary_demux_3_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [1:0] sb;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b0, b1, b2;
    logic [2:0] b_valid;
    logic [2:0] b_ready;
    logic       err;
    logic [7:0] drop_cnt;

    logic       a_ready_s;
    logic [7:0] b0_s, b1_s, b2_s;
    logic [2:0] b_valid_s;
    logic       err_s;
    logic [1:0] drop_cnt_s;

    binary_demux_3_stream #(.k(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .sb(sb), .a_valid(a_valid), .a_ready(a_ready),
        .b0(b0), .b1(b1), .b2(b2), .b_valid(b_valid), .b_ready(b_ready),
        .err(err), .drop_cnt(drop_cnt)
    );

    // Narrow-counter copy sharing all inputs, used only to observe saturation.
    binary_demux_3_stream #(.k(8), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .a(a), .sb(sb), .a_valid(a_valid), .a_ready(a_ready_s),
        .b0(b0_s), .b1(b1_s), .b2(b2_s), .b_valid(b_valid_s), .b_ready(b_ready),
        .err(err_s), .drop_cnt(drop_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb_q [3][$];
    logic [2:0] mv;
    logic       m_err;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt_s;
    logic       seen_ready;
    logic       last_acc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] chanData(input int i);
        case (i)
            0:       return b0;
            1:       return b1;
            default: return b2;
        endcase
    endfunction

    task automatic resetModel();
        mv      = 3'b000;
        m_err   = 1'b0;
        m_cnt   = '0;
        m_cnt_s = '0;
        for (int i = 0; i < 3; i++) sb_q[i].delete();
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic stepCycle();
        logic       ex_ready;
        logic [2:0] nv;
        logic [7:0] w;
        #1;
        ex_ready   = (sb == 2'd3) ? 1'b1 : (~mv[sb] | b_ready[sb]);
        seen_ready = a_ready;
        checkOutput("a_ready", a_ready, ex_ready);
        nv = mv;
        for (int i = 0; i < 3; i++) begin
            if (mv[i] && b_ready[i]) begin
                if (sb_q[i].size() == 0) begin
                    checkOutput($sformatf("b%0d_underflow", i), 1, 0);
                end else begin
                    w = sb_q[i].pop_front();
                    checkOutput($sformatf("b%0d_out", i), chanData(i), w);
                end
                nv[i] = 1'b0;
            end
        end
        last_acc = a_valid & ex_ready;
        if (last_acc) begin
            if (sb == 2'd3) begin
                m_err = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                if (m_cnt_s != 2'b11) m_cnt_s = m_cnt_s + 2'd1;
            end else begin
                sb_q[sb].push_back(a);
                nv[sb] = 1'b1;
            end
        end
        mv = nv;
        @(posedge clk);
        #1;
        checkOutput("b_valid", b_valid, mv);
        checkOutput("err", err, m_err);
        checkOutput("drop_cnt", drop_cnt, m_cnt);
        checkOutput("drop_cnt_small", drop_cnt_s, m_cnt_s);
        for (int i = 0; i < 3; i++) begin
            if (mv[i] && sb_q[i].size() != 0)
                checkOutput($sformatf("b%0d_held", i), chanData(i), sb_q[i][0]);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic av, input logic [1:0] s, input logic [7:0] d,
                                 input logic [2:0] br);
        a_valid = av;
        sb      = s;
        a       = d;
        b_ready = br;
        stepCycle();
    endtask

    initial begin
        logic [2:0] bv_before;
        logic [7:0] rd;
        logic [1:0] rs;
        logic       rv;
        logic       pending;

        rst_n   = 1'b0;
        a       = '0;
        sb      = 2'd0;
        a_valid = 1'b0;
        b_ready = 3'b000;
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_b_valid", b_valid, 3'b000);
        checkOutput("rst_b0", b0, 8'h00);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_drop_cnt", drop_cnt, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] routing");
        applyStimulus(1'b1, 2'd0, 8'hA5, 3'b111);
        checkOutput("t2_v0", b_valid, 3'b001);
        checkOutput("t2_b0", b0, 8'hA5);
        applyStimulus(1'b1, 2'd1, 8'h3C, 3'b111);
        checkOutput("t2_v1", b_valid, 3'b010);
        checkOutput("t2_b1", b1, 8'h3C);
        applyStimulus(1'b1, 2'd2, 8'hF0, 3'b111);
        checkOutput("t2_v2", b_valid, 3'b100);
        checkOutput("t2_b2", b2, 8'hF0);
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 2'd1, 8'h11, 3'b101);
        applyStimulus(1'b1, 2'd0, 8'h33, 3'b101);
        checkOutput("t3_b0", b0, 8'h33);
        applyStimulus(1'b1, 2'd1, 8'h22, 3'b101);
        checkOutput("t3_blocked", seen_ready, 1'b0);
        checkOutput("t3_b1_hold", b1, 8'h11);
        applyStimulus(1'b1, 2'd1, 8'h22, 3'b101);
        checkOutput("t3_blocked2", seen_ready, 1'b0);
        applyStimulus(1'b1, 2'd1, 8'h22, 3'b111);
        checkOutput("t3_release", seen_ready, 1'b1);
        checkOutput("t3_b1_new", b1, 8'h22);

        $display("[TB] full throughput");
        for (int n = 0; n < 16; n++) begin
            applyStimulus(1'b1, 2'd2, 8'(n * 7 + 1), 3'b111);
            checkOutput("t4_ready", seen_ready, 1'b1);
            checkOutput("t4_valid2", b_valid[2], 1'b1);
            checkOutput("t4_b2", b2, 8'(n * 7 + 1));
        end

        $display("[TB] illegal select");
        checkOutput("t5_err_pre", err, 1'b0);
        bv_before = b_valid;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 2'd3, 8'(8'hC0 + n), 3'b000);
            checkOutput("t5_ready", seen_ready, 1'b1);
        end
        checkOutput("t5_bv", b_valid, bv_before);
        checkOutput("t5_err", err, 1'b1);
        checkOutput("t5_cnt3", drop_cnt, 8'd3);
        for (int n = 0; n < 2; n++) applyStimulus(1'b1, 2'd3, 8'hCC, 3'b000);
        checkOutput("t5_cnt5", drop_cnt, 8'd5);
        checkOutput("t5_sat", drop_cnt_s, 2'b11);

        $display("[TB] async reset");
        applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);
        applyStimulus(1'b1, 2'd0, 8'h61, 3'b000);
        applyStimulus(1'b1, 2'd1, 8'h62, 3'b000);
        applyStimulus(1'b1, 2'd2, 8'h63, 3'b000);
        checkOutput("t1_full", b_valid, 3'b111);
        a_valid = 1'b1;
        sb      = 2'd0;
        a       = 8'h77;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t1_bv", b_valid, 3'b000);
        checkOutput("t1_err", err, 1'b0);
        checkOutput("t1_cnt", drop_cnt, 8'h00);
        checkOutput("t1_b2", b2, 8'h00);
        resetModel();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd0, 8'h77, 3'b000);
        checkOutput("t1_first_acc", seen_ready, 1'b1);
        checkOutput("t1_b0", b0, 8'h77);

        $display("[TB] random");
        pending = 1'b0;
        rv = 1'b0; rs = 2'd0; rd = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            if (!pending) begin
                rv = ($urandom_range(3) != 0);
                rs = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
                rd = 8'($urandom);
            end
            applyStimulus(rv, rs, rd, 3'($urandom));
            pending = rv & ~last_acc;
        end
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 2'd0, 8'h00, 3'b111);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("drain_q%0d", i), sb_q[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
